// File: rtl/datapath_sequencer.sv
// Sequences fetch/peek/load/loadv reads and flag ops into datapath mode selects.
// Latency: RAM ops respond 2 cycles after acceptance, flag ops 1 cycle; req_ready only in IDLE.
module datapath_sequencer #(
  parameter int WORD_SIZE        = 16,
  parameter int MODE_SELECT_SIZE = 3,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [2:0]                  req_op,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  output logic                        req_ready,
  input  logic                        pc_load,
  input  logic [ADDR_WIDTH-1:0]       pc_load_value,
  input  logic                        halt,
  output logic [MODE_SELECT_SIZE-1:0] mode,
  output logic [ADDR_WIDTH-1:0]       p_ram_addr,
  output logic [ADDR_WIDTH-1:0]       v_ram_addr,
  output logic                        p_ram_re,
  output logic                        v_ram_re,
  output logic [ADDR_WIDTH-1:0]       pc,
  output logic                        rsp_valid,
  output logic                        rsp_err,
  output logic                        busy
);

  if (WORD_SIZE < 1) begin : g_word_size_check
    $error("WORD_SIZE must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, FLAG} state_t;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_LOADV = 3'd3;
  localparam logic [2:0] OP_SET   = 3'd4;
  localparam logic [2:0] OP_CLR   = 3'd5;

  // Peek select is harmless to the instruction and load registers, so idle parks there.
  localparam logic [MODE_SELECT_SIZE-1:0] MODE_PARK = MODE_SELECT_SIZE'(1);

  state_t                state_q;
  state_t                state_d;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  accept;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_op[2] ? FLAG : READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      FLAG:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !halt && !pc_load && !rst;
    mode      = MODE_PARK;
    p_ram_re  = 1'b0;
    v_ram_re  = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      READ: begin
        p_ram_re = (op_q != OP_LOADV);
        v_ram_re = (op_q == OP_LOADV);
      end
      CAPTURE: begin
        mode      = MODE_SELECT_SIZE'(op_q);
        rsp_valid = 1'b1;
      end
      FLAG: begin
        if (op_q == OP_SET || op_q == OP_CLR) begin
          mode = MODE_SELECT_SIZE'(op_q);
        end
        rsp_valid = 1'b1;
        rsp_err   = (op_q[2:1] == 2'b11);
      end
      default: ;
    endcase
  end

  assign p_ram_addr = (op_q == OP_LOAD) ? addr_q : pc;
  assign v_ram_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_FETCH;
      addr_q <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      addr_q <= req_addr;
    end
  end

  // The fetch increment lands on the READ->CAPTURE edge so CAPTURE already shows pc+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (state_q == IDLE && pc_load) begin
      pc <= pc_load_value;
    end else if (state_q == READ && op_q == OP_FETCH) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: hand-computed expectations checked by immediate assertions.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_op;
  logic [7:0] req_addr;
  logic       req_ready;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic       halt;
  logic [2:0] mode;
  logic [7:0] p_ram_addr;
  logic [7:0] v_ram_addr;
  logic       p_ram_re;
  logic       v_ram_re;
  logic [7:0] pc;
  logic       rsp_valid;
  logic       rsp_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(
    .WORD_SIZE(16),
    .MODE_SELECT_SIZE(3),
    .ADDR_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .pc_load(pc_load),
    .pc_load_value(pc_load_value),
    .halt(halt),
    .mode(mode),
    .p_ram_addr(p_ram_addr),
    .v_ram_addr(v_ram_addr),
    .p_ram_re(p_ram_re),
    .v_ram_re(v_ram_re),
    .pc(pc),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 8'h00;
    pc_load = 1'b0; pc_load_value = 8'h00; halt = 1'b0;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mode", mode, 1);
    chk("rst_pc", pc, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_pre", p_ram_re, 0);
    rst = 1'b0; #1;
    chk("post_rst_ready", req_ready, 1);

    // fetch at pc=0; op input changes after acceptance must be ignored
    req_valid = 1'b1; req_op = 3'd0;
    tick();
    req_valid = 1'b0; req_op = 3'd5;
    chk("f_busy", busy, 1);
    chk("f_pre", p_ram_re, 1);
    chk("f_paddr", p_ram_addr, 8'h00);
    chk("f_vre", v_ram_re, 0);
    chk("f_rsp_early", rsp_valid, 0);
    chk("f_mode_read", mode, 1);
    tick();
    chk("f_mode", mode, 0);
    chk("f_rsp", rsp_valid, 1);
    chk("f_err", rsp_err, 0);
    chk("f_pc", pc, 1);
    chk("f_pre_off", p_ram_re, 0);
    tick();
    chk("f_idle", busy, 0);
    chk("f_rsp_off", rsp_valid, 0);

    // jump to 0xFF: pc_load beats req_valid
    pc_load = 1'b1; pc_load_value = 8'hFF; req_valid = 1'b1; req_op = 3'd0; #1;
    chk("jl_ready", req_ready, 0);
    tick();
    pc_load = 1'b0;
    chk("jl_pc", pc, 8'hFF);
    chk("jl_not_acc", busy, 0);
    // two back-to-back fetches with req_valid held
    tick();
    chk("w1_paddr", p_ram_addr, 8'hFF);
    chk("w1_pre", p_ram_re, 1);
    tick();
    chk("w1_ready_cap", req_ready, 0);
    chk("w1_rsp", rsp_valid, 1);
    chk("w1_pc", pc, 8'h00);
    tick();
    chk("w2_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("w2_paddr", p_ram_addr, 8'h00);
    tick();
    chk("w2_pc", pc, 8'h01);
    tick();

    // loadv 0x2A; address change after acceptance ignored
    req_valid = 1'b1; req_op = 3'd3; req_addr = 8'h2A;
    tick();
    req_valid = 1'b0; req_addr = 8'h55;
    chk("lv_vre", v_ram_re, 1);
    chk("lv_vaddr", v_ram_addr, 8'h2A);
    chk("lv_pre", p_ram_re, 0);
    tick();
    chk("lv_mode", mode, 3);
    chk("lv_rsp", rsp_valid, 1);
    chk("lv_pc", pc, 8'h01);
    tick();

    // load 0x33
    req_valid = 1'b1; req_op = 3'd2; req_addr = 8'h33;
    tick();
    req_valid = 1'b0;
    chk("ld_pre", p_ram_re, 1);
    chk("ld_paddr", p_ram_addr, 8'h33);
    tick();
    chk("ld_mode", mode, 2);
    chk("ld_pc", pc, 8'h01);
    tick();

    // flag ops 4, 5 and illegal 7
    req_valid = 1'b1; req_op = 3'd4;
    tick();
    req_valid = 1'b0;
    chk("op4_mode", mode, 4);
    chk("op4_rsp", rsp_valid, 1);
    chk("op4_err", rsp_err, 0);
    tick();
    chk("op4_idle", busy, 0);
    req_valid = 1'b1; req_op = 3'd5;
    tick();
    req_valid = 1'b0;
    chk("op5_mode", mode, 5);
    chk("op5_err", rsp_err, 0);
    tick();
    req_valid = 1'b1; req_op = 3'd7;
    tick();
    req_valid = 1'b0;
    chk("op7_mode", mode, 1);
    chk("op7_rsp", rsp_valid, 1);
    chk("op7_err", rsp_err, 1);
    chk("op7_pre", p_ram_re, 0);
    chk("op7_vre", v_ram_re, 0);
    tick();
    chk("op7_idle", busy, 0);
    chk("op7_err_off", rsp_err, 0);

    // reset during READ of a load
    req_valid = 1'b1; req_op = 3'd2; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    chk("rr_pre", p_ram_re, 1);
    rst = 1'b1;
    tick();
    chk("rr_busy", busy, 0);
    chk("rr_rsp", rsp_valid, 0);
    chk("rr_pc", pc, 0);
    chk("rr_mode", mode, 1);
    rst = 1'b0;
    tick();
    chk("rr_rsp_after", rsp_valid, 0);

    // peek with halt raised after acceptance; pc_load in READ ignored
    pc_load = 1'b1; pc_load_value = 8'h40;
    tick();
    pc_load = 1'b0;
    chk("pk_pc_set", pc, 8'h40);
    req_valid = 1'b1; req_op = 3'd1;
    tick();
    halt = 1'b1; pc_load = 1'b1; pc_load_value = 8'h77;
    chk("pk_pre", p_ram_re, 1);
    chk("pk_paddr", p_ram_addr, 8'h40);
    tick();
    pc_load = 1'b0;
    chk("pk_mode", mode, 1);
    chk("pk_rsp", rsp_valid, 1);
    chk("pk_pc", pc, 8'h40);
    tick();
    chk("pk_halt_ready", req_ready, 0);
    tick();
    chk("pk_halt_busy", busy, 0);
    chk("pk_halt_pc", pc, 8'h40);
    halt = 1'b0; #1;
    chk("pk_unhalt_ready", req_ready, 1);
    req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
